// File: rtl/alu_issue_queue.sv
// alu_issue_queue: DEPTH-entry request FIFO feeding a 16-bit ALU, registered handshaked result stage, operand-A forwarding from the last issued result
module alu_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [15:0]             in_a,
  input  logic [15:0]             in_b,
  input  logic [3:0]              in_sel,
  input  logic                    in_fwd,
  output logic [15:0]             alu_a,
  output logic [15:0]             alu_b,
  output logic [3:0]              alu_sel,
  input  logic [15:0]             alu_result,
  input  logic                    alu_carry,
  input  logic                    alu_zero,
  input  logic                    alu_overflow,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_result,
  output logic [3:0]              out_sel,
  output logic                    out_carry,
  output logic                    out_zero,
  output logic                    out_overflow,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [15:0]             op_count
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sel;
    logic        fwd;
  } req_t;
  req_t          mem [DEPTH];
  req_t          head;
  logic [AW-1:0] wp, rp;
  logic [15:0]   last_result;
  logic          busy, push, issue;
  assign busy     = |occupancy;
  assign in_ready = !occupancy[AW] && !rst;
  assign push     = in_valid && in_ready;
  assign issue    = busy && (!out_valid || out_ready);
  assign head     = mem[rp];
  assign alu_a    = busy ? (head.fwd ? last_result : head.a) : '0;
  assign alu_b    = busy ? head.b : '0;
  assign alu_sel  = busy ? head.sel : '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {in_a, in_b, in_sel, in_fwd};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp           <= '0;
      rp           <= '0;
      occupancy    <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_sel      <= '0;
      out_carry    <= 1'b0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
      last_result  <= '0;
      op_count     <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (issue) begin
        rp           <= rp + AW'(1);
        out_valid    <= 1'b1;
        out_result   <= alu_result;
        out_sel      <= head.sel;
        out_carry    <= alu_carry;
        out_zero     <= alu_zero;
        out_overflow <= alu_overflow;
        last_result  <= alu_result;
        op_count     <= op_count + 16'd1;
      end else if (out_ready) begin
        out_valid    <= 1'b0;
      end
      if (push != issue) occupancy <= push ? occupancy + (AW+1)'(1) : occupancy - (AW+1)'(1);
    end
endmodule
